matmul_seq_ctrl: RTL and testbench

//   Parametrised sequencing controller for the matrix multiplier datapath; computes C = A*B.

---
 rtl/matmul_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequencing controller for a matrix-multiply datapath (C = A*B).
// Walks C[r][c] in row-major order; for each element it clears the accumulator,
// issues INNER multiply-accumulates and then one store.
//
// Ports
//   i_clock          rising-edge clock
//   i_reset          asynchronous active-high reset
//   i_start          begin a multiply (sampled only in IDLE)
//   i_operand_valid  A/B operands valid on the datapath this cycle
//   i_store_ready    result sink accepts a write this cycle
//   o_busy           high in every state except IDLE
//   o_clear_acc      zero the accumulator (CLEAR)
//   o_mac_en         accumulate A[row][k]*B[k][col]
//   o_store          write accumulator to C[row][col]
//   o_row_idx        current output row
//   o_col_idx        current output column
//   o_k_idx          current inner-product term
//   o_done           one-cycle pulse when the matrix is complete
module matmul_seq_ctrl #(
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 2,
  parameter int unsigned INNER = 2,
  parameter int unsigned IDX_W = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_operand_valid,
  input  logic             i_store_ready,
  output logic             o_busy,
  output logic             o_clear_acc,
  output logic             o_mac_en,
  output logic             o_store,
  output logic [IDX_W-1:0] o_row_idx,
  output logic [IDX_W-1:0] o_col_idx,
  output logic [IDX_W-1:0] o_k_idx,
  output logic             o_done
);

  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(INNER - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] w_row_nxt;
  logic [IDX_W-1:0] w_col_nxt;
  logic [IDX_W-1:0] w_k_nxt;
  logic             r_busy;
  logic             r_clear;
  logic             r_mac_phase;
  logic             r_store;
  logic             r_done;
  logic             w_last_col;
  logic             w_last_row;

  assign w_last_col = (r_col == COL_LAST);
  assign w_last_row = (r_row == ROW_LAST);

  // Next-state and index update
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        w_row_nxt = '0;
        w_col_nxt = '0;
        w_k_nxt   = '0;
        if (i_start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_k_nxt     = '0;
        w_state_nxt = S_MAC;
      end
      S_MAC: begin
        if (i_operand_valid) begin
          if (r_k == K_LAST) w_state_nxt = S_STORE;
          else               w_k_nxt     = r_k + IDX_W'(1);
        end
      end
      S_STORE: begin
        if (i_store_ready) begin
          if (w_last_col) begin
            if (w_last_row) begin
              w_state_nxt = S_DONE;
            end else begin
              w_col_nxt   = '0;
              w_row_nxt   = r_row + IDX_W'(1);
              w_state_nxt = S_CLEAR;
            end
          end else begin
            w_col_nxt   = r_col + IDX_W'(1);
            w_state_nxt = S_CLEAR;
          end
        end
      end
      S_DONE: begin
        w_row_nxt   = '0;
        w_col_nxt   = '0;
        w_k_nxt     = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_row_nxt   = '0;
        w_col_nxt   = '0;
        w_k_nxt     = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, indices and state-decoded flags; flags are decoded from the next state
  // so they line up with the state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_clear     <= 1'b0;
      r_mac_phase <= 1'b0;
      r_store     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_k         <= w_k_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_clear     <= (w_state_nxt == S_CLEAR);
      r_mac_phase <= (w_state_nxt == S_MAC);
      r_store     <= (w_state_nxt == S_STORE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign o_busy      = r_busy;
  assign o_clear_acc = r_clear;
  // mac_en is qualified by the operand handshake so the datapath accumulates
  // only in cycles where the operands are actually present
  assign o_mac_en    = r_mac_phase & i_operand_valid;
  assign o_store     = r_store;
  assign o_done      = r_done;
  assign o_row_idx   = r_row;
  assign o_col_idx   = r_col;
  assign o_k_idx     = r_k;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Testbench for matmul_seq_ctrl: directed runs with a scoreboard of expected
// stores, done cycles and MAC counts, plus a 3x1x1 instance.
module tb_matmul_seq_ctrl;

  typedef struct packed {
    int row;
    int col;
  } rc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ov = 1'b1;
  logic       sr = 1'b1;
  logic       busy, clr, mac, st, done;
  logic [3:0] row, col, k;

  logic       start3 = 1'b0;
  logic       ov3 = 1'b1;
  logic       sr3 = 1'b1;
  logic       busy3, clr3, mac3, st3, done3;
  logic [3:0] row3, col3, k3;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mac_cnt = 0;
  int mac_cnt3 = 0;

  rc_t exp_store_q[$];
  int  exp_done_q[$];
  int  exp_mac_q[$];
  rc_t exp_store3_q[$];
  int  exp_done3_q[$];
  int  exp_mac3_q[$];

  matmul_seq_ctrl u_dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .i_operand_valid(ov), .i_store_ready(sr),
    .o_busy(busy), .o_clear_acc(clr), .o_mac_en(mac), .o_store(st),
    .o_row_idx(row), .o_col_idx(col), .o_k_idx(k), .o_done(done)
  );

  matmul_seq_ctrl #(.ROWS(3), .COLS(1), .INNER(1), .IDX_W(4)) u_dut3 (
    .i_clock(clk), .i_reset(rst), .i_start(start3),
    .i_operand_valid(ov3), .i_store_ready(sr3),
    .o_busy(busy3), .o_clear_acc(clr3), .o_mac_en(mac3), .o_store(st3),
    .o_row_idx(row3), .o_col_idx(col3), .o_k_idx(k3), .o_done(done3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Default 2x2x2 pass: four stores in row-major order, 8 MACs
  task automatic push_run(input int done_cyc);
    rc_t x;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        x.row = r;
        x.col = c;
        exp_store_q.push_back(x);
      end
    exp_done_q.push_back(done_cyc);
    exp_mac_q.push_back(8);
  endtask

  // Called just after a rising edge; e is the edge that samples start
  task automatic do_start(output int e);
    start = 1'b1;
    e = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin : mon
    rc_t x;
    if (rst) begin
      mac_cnt = 0;
    end else begin
      if (busy) begin
        chk("row_bound", int'(row < 4'd2), 1);
        chk("col_bound", int'(col < 4'd2), 1);
        chk("k_bound", int'(k < 4'd2), 1);
      end
      if (mac) mac_cnt++;
      if (st && sr) begin
        if (exp_store_q.size() == 0) flag_fail("store_unexpected");
        else begin
          x = exp_store_q.pop_front();
          chk("store_row", int'(row), x.row);
          chk("store_col", int'(col), x.col);
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) flag_fail("done_unexpected");
        else begin
          chk("done_cycle", cyc, exp_done_q.pop_front());
          chk("mac_count", mac_cnt, exp_mac_q.pop_front());
        end
        mac_cnt = 0;
      end
    end
  end

  // Monitor for the 3x1x1 instance
  always @(negedge clk) begin : mon3
    rc_t x;
    if (rst) begin
      mac_cnt3 = 0;
    end else begin
      if (mac3) begin
        mac_cnt3++;
        chk("k3_on_mac", int'(k3), 0);
      end
      if (st3 && sr3) begin
        if (exp_store3_q.size() == 0) flag_fail("store3_unexpected");
        else begin
          x = exp_store3_q.pop_front();
          chk("store3_row", int'(row3), x.row);
          chk("store3_col", int'(col3), x.col);
          chk("store3_k", int'(k3), 0);
        end
      end
      if (done3) begin
        if (exp_done3_q.size() == 0) flag_fail("done3_unexpected");
        else begin
          chk("done3_cycle", cyc, exp_done3_q.pop_front());
          chk("mac3_count", mac_cnt3, exp_mac3_q.pop_front());
        end
        mac_cnt3 = 0;
      end
    end
  end

  initial begin : stim
    int e;
    rc_t x;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clear", int'(clr), 0);
    chk("rst_store", int'(st), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_k", int'(k), 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: stall-free pass
    do_start(e);
    push_run(e + 16);
    @(negedge clk);
    chk("t1_first_clear", int'(clr), 1);
    chk("t1_first_busy", int'(busy), 1);
    wait_cyc(e + 17);
    @(negedge clk);
    chk("t1_idle_busy", int'(busy), 0);
    tick();

    // 2: operand stall at k=1 of element (0,1)
    do_start(e);
    push_run(e + 19);
    wait_cyc(e + 6);
    ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_k", int'(k), 1);
      chk("t2_stall_col", int'(col), 1);
      chk("t2_stall_mac", int'(mac), 0);
      tick();
    end
    ov = 1'b1;
    wait_cyc(e + 21);

    // 3: store_ready stall at element (1,0)
    do_start(e);
    push_run(e + 18);
    wait_cyc(e + 11);
    sr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) sr = 1'b1;
      @(negedge clk);
      chk("t3_store_held", int'(st), 1);
      chk("t3_store_row", int'(row), 1);
      chk("t3_store_col", int'(col), 0);
      tick();
    end
    @(negedge clk);
    chk("t3_next_clear", int'(clr), 1);
    chk("t3_next_row", int'(row), 1);
    chk("t3_next_col", int'(col), 1);
    wait_cyc(e + 20);

    // 4: asynchronous reset mid-MAC of element (1,0)
    for (int c = 0; c < 2; c++) begin
      x.row = 0;
      x.col = c;
      exp_store_q.push_back(x);
    end
    do_start(e);
    wait_cyc(e + 9);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_busy", int'(busy), 0);
    chk("t4_mac", int'(mac), 0);
    chk("t4_clear", int'(clr), 0);
    chk("t4_store", int'(st), 0);
    chk("t4_row", int'(row), 0);
    chk("t4_col", int'(col), 0);
    chk("t4_k", int'(k), 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    do_start(e);
    push_run(e + 16);
    wait_cyc(e + 18);

    // 5: start held high and re-pulsed while busy
    start = 1'b1;
    e = cyc + 1;
    push_run(e + 16);
    push_run(e + 18 + 16);
    tick();
    wait_cyc(e + 5);
    start = 1'b0;
    tick();
    start = 1'b1;
    wait_cyc(e + 17);
    @(negedge clk);
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_idle_clear", int'(clr), 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t5_restart_clear", int'(clr), 1);
    chk("t5_restart_row", int'(row), 0);
    chk("t5_restart_col", int'(col), 0);
    wait_cyc(e + 37);
    @(negedge clk);
    chk("t5_final_busy", int'(busy), 0);
    tick();

    // 6: ROWS=3, COLS=1, INNER=1
    for (int r = 0; r < 3; r++) begin
      x.row = r;
      x.col = 0;
      exp_store3_q.push_back(x);
    end
    start3 = 1'b1;
    e = cyc + 1;
    exp_done3_q.push_back(e + 9);
    exp_mac3_q.push_back(3);
    tick();
    start3 = 1'b0;
    wait_cyc(e + 11);
    @(negedge clk);
    chk("t6_idle_busy", int'(busy3), 0);

    chk("store_q_left", exp_store_q.size(), 0);
    chk("done_q_left", exp_done_q.size(), 0);
    chk("store3_q_left", exp_store3_q.size(), 0);
    chk("done3_q_left", exp_done3_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
